// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU and a debug/loader port,
// with bounded bursts and round-robin hand-over so neither requester starves.
`default_nettype none

module dmem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CPU  = 2'd1,
      S_DBG  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic               last_dbg_q, last_dbg_d;
   logic               rd_pend_q, rd_pend_d;
   logic               rd_dbg_q, rd_dbg_d;

   logic               cpu_win, dbg_win, cnt_max;
   logic [CNT_W-1:0]   cnt_inc;

   assign cnt_max = (burst_cnt_q == C_MAX);
   assign cnt_inc = cnt_max ? C_MAX : burst_cnt_q + CNT_W'(1);

   // Grants are gated by reset so nothing reaches memory while rst_ni is low.
   always_comb begin
      cpu_win = 1'b0;
      dbg_win = 1'b0;
      if (rst_ni) begin
         case (state_q)
            S_IDLE: begin
               if (cpu_req_i && dbg_req_i) begin
                  cpu_win = last_dbg_q;
                  dbg_win = !last_dbg_q;
               end else begin
                  cpu_win = cpu_req_i;
                  dbg_win = dbg_req_i;
               end
            end
            S_CPU: begin
               if (cpu_req_i && !(dbg_req_i && cnt_max)) cpu_win = 1'b1;
               else                                     dbg_win = dbg_req_i;
            end
            S_DBG: begin
               if (dbg_req_i && !(cpu_req_i && cnt_max)) dbg_win = 1'b1;
               else                                     cpu_win = cpu_req_i;
            end
            default: begin
               cpu_win = 1'b0;
               dbg_win = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      state_d     = S_IDLE;
      burst_cnt_d = '0;
      last_dbg_d  = last_dbg_q;
      rd_pend_d   = 1'b0;
      rd_dbg_d    = rd_dbg_q;
      if (cpu_win) begin
         state_d     = S_CPU;
         burst_cnt_d = (state_q == S_CPU) ? cnt_inc : CNT_W'(1);
         last_dbg_d  = 1'b0;
         rd_pend_d   = !cpu_we_i;
         rd_dbg_d    = 1'b0;
      end else if (dbg_win) begin
         state_d     = S_DBG;
         burst_cnt_d = (state_q == S_DBG) ? cnt_inc : CNT_W'(1);
         last_dbg_d  = 1'b1;
         rd_pend_d   = !dbg_we_i;
         rd_dbg_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         burst_cnt_q <= '0;
         last_dbg_q  <= 1'b1;
         rd_pend_q   <= 1'b0;
         rd_dbg_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         last_dbg_q  <= last_dbg_d;
         rd_pend_q   <= rd_pend_d;
         rd_dbg_q    <= rd_dbg_d;
      end
   end

   always_comb begin
      mem_en_o    = cpu_win | dbg_win;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (cpu_win) begin
         mem_we_o    = cpu_we_i;
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
      end else if (dbg_win) begin
         mem_we_o    = dbg_we_i;
         mem_addr_o  = dbg_addr_i;
         mem_wdata_o = dbg_wdata_i;
      end
   end

   assign cpu_gnt_o    = cpu_win;
   assign dbg_gnt_o    = dbg_win;
   assign cpu_rvalid_o = rd_pend_q && !rd_dbg_q;
   assign dbg_rvalid_o = rd_pend_q && rd_dbg_q;
   assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
   assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a behavioural arbitration/memory model checked every cycle.
`default_nettype none

module tb_dmem_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [7:0]  cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [15:0] cpu_rdata, dbg_rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;

   logic [15:0] mem     [256];
   logic [15:0] ref_mem [256];

   int tests = 0;
   int fails = 0;

   // Model state: owner/last 0=none 1=CPU 2=DBG
   int          m_owner  = 0;
   int          m_streak = 0;
   int          m_last   = 2;
   int          m_rv_who = 0;
   logic [15:0] m_rv_data = 16'h0;
   int          exp_win  = 0;

   dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(MAXB)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   // Environment memory: single port, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_winner();
      if (!rst_n) return 0;
      if (cpu_req && dbg_req) begin
         if (m_owner == 0) return (m_last == 2) ? 1 : 2;
         if (m_streak >= MAXB) return 3 - m_owner;
         return m_owner;
      end
      if (cpu_req) return 1;
      if (dbg_req) return 2;
      return 0;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = 0; m_streak = 0; m_last = 2; m_rv_who = 0;
      end else begin
         m_rv_who = 0;
         if (exp_win != 0) begin
            m_streak = (exp_win == m_owner) ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 1;
            m_owner  = exp_win;
            m_last   = exp_win;
            if (exp_win == 1) begin
               if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
               else begin m_rv_who = 1; m_rv_data = ref_mem[cpu_addr]; end
            end else begin
               if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
               else begin m_rv_who = 2; m_rv_data = ref_mem[dbg_addr]; end
            end
         end else begin
            m_owner = 0; m_streak = 0;
         end
      end
   end

   always @(negedge clk) begin
      exp_win = model_winner();
      chk("cpu_gnt", 32'(cpu_gnt), 32'(exp_win == 1));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(exp_win == 2));
      chk("mem_en",  32'(mem_en),  32'(exp_win != 0));
      if (exp_win == 1) begin
         chk("mem_we",    32'(mem_we),    32'(cpu_we));
         chk("mem_addr",  32'(mem_addr),  32'(cpu_addr));
         chk("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      end else if (exp_win == 2) begin
         chk("mem_we",    32'(mem_we),    32'(dbg_we));
         chk("mem_addr",  32'(mem_addr),  32'(dbg_addr));
         chk("mem_wdata", 32'(mem_wdata), 32'(dbg_wdata));
      end
      if (!rst_n) begin
         chk("rst_mem_addr",  32'(mem_addr),  32'h0);
         chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      end
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(rst_n && m_rv_who == 1));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(rst_n && m_rv_who == 2));
      chk("cpu_rdata",  32'(cpu_rdata),  (rst_n && m_rv_who == 1) ? 32'(m_rv_data) : 32'h0);
      chk("dbg_rdata",  32'(dbg_rdata),  (rst_n && m_rv_who == 2) ? 32'(m_rv_data) : 32'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq[$];
      int exp_seq[9] = '{2, 2, 2, 2, 1, 2, 2, 2, 2};
      int done;
      logic g_cpu, g_dbg;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'(i * 10);
         ref_mem[i] = 16'(i * 10);
      end
      rst_n = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05; cpu_wdata = 16'h0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 16'h5555;
      #2 rst_n = 1'b0;

      // Reset held with both requesting
      repeat (3) step();
      @(negedge clk);
      chk("t1_rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
      chk("t1_rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
      chk("t1_rst_mem_en",  32'(mem_en),  32'h0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_first_tie_cpu", 32'(cpu_gnt), 32'h1);
      chk("t1_first_tie_dbg", 32'(dbg_gnt), 32'h0);
      idle(3);

      // Lone CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
      @(negedge clk);
      chk("t2_cpu_gnt",  32'(cpu_gnt),  32'h1);
      chk("t2_mem_en",   32'(mem_en),   32'h1);
      chk("t2_mem_addr", 32'(mem_addr), 32'h05);
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("t2_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
      chk("t2_cpu_rdata",  32'(cpu_rdata),  32'd50);
      chk("t2_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
      idle(2);

      // Alternating reads
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h01;
      @(negedge clk);
      chk("t4_dbg_gnt", 32'(dbg_gnt), 32'h1);
      step();
      dbg_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h02;
      @(negedge clk);
      chk("t4_cpu_gnt",    32'(cpu_gnt),    32'h1);
      chk("t4_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
      chk("t4_dbg_rdata",  32'(dbg_rdata),  32'd10);
      chk("t4_cpu_rvalid0", 32'(cpu_rvalid), 32'h0);
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("t4_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
      chk("t4_cpu_rdata",  32'(cpu_rdata),  32'd20);
      chk("t4_dbg_rdata0", 32'(dbg_rdata),  32'h0);
      idle(2);

      // Burst limit: dbg streams writes while CPU waits on a read
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h00; dbg_wdata = 16'hA000;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      done = 0;
      for (int cyc = 0; cyc < 20 && done < 8; cyc++) begin
         @(negedge clk);
         g_cpu = cpu_gnt;
         g_dbg = dbg_gnt;
         if (g_dbg) seq.push_back(2);
         else if (g_cpu) seq.push_back(1);
         step();
         if (g_dbg) begin
            done++;
            if (done < 8) begin
               dbg_addr  = dbg_addr + 8'h1;
               dbg_wdata = dbg_wdata + 16'h1;
            end else dbg_req = 1'b0;
         end
         if (g_cpu) cpu_req = 1'b0;
      end
      chk("t3_grant_count", 32'(seq.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         if (i < seq.size()) chk("t3_grant_seq", 32'(seq[i]), 32'(exp_seq[i]));
      idle(2);

      // Write then read of the same address
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 16'h1234;
      step();
      dbg_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
      chk("t5_cpu_rdata",  32'(cpu_rdata),  32'h1234);
      idle(2);

      // Reset with a read outstanding
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
      @(negedge clk);
      chk("t6_cpu_gnt", 32'(cpu_gnt), 32'h1);
      step();
      cpu_req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_rvalid", 32'(cpu_rvalid), 32'h0);
      step();
      rst_n = 1'b1;
      cpu_req = 1'b1; cpu_addr = 8'h31;
      @(negedge clk);
      chk("t6_post_rvalid", 32'(cpu_rvalid), 32'h0);
      chk("t6_post_gnt",    32'(cpu_gnt),    32'h1);
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("t6_post_rdata", 32'(cpu_rdata), 32'd490);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
